segmented_display_mux: RTL and testbench
========================================

Name: segmented_display_mux

Overview:
Next-generation multiplexed 7/8-segment LED display driver; parametrised digit count, polarities and scan rate, entirely in one clock domain (no derived clocks).
Adds per-digit blanking dead-time (removes ghosting), 4-bit PWM brightness, and a double-buffered load so displayed data only changes at frame boundaries.
Sits between status/counter logic and the board's common-anode/common-cathode display pins.

Parameters:
NUMBER_OF_DIGITS, 4, digits scanned; any value 1..16, not restricted to powers of 2
NUMBER_OF_SEGMENTS, 8, 7 (a..g) or 8 (a..g + dp); other values are illegal
CLOCK_DIVIDE_LOG2, 4, one scan tick every 2^CLOCK_DIVIDE_LOG2 clocks
BLANK_TICKS, 2, ticks at the start of each digit slot with anodes and cathodes inactive (0..15)
ANODE_ACTIVE_HIGH, 1, 1: asserted anode = 1; 0: asserted anode = 0
CATHODE_ACTIVE_LOW, 1, 1: lit segment = 0; 0: lit segment = 1

Ports:
clock  input  1  system clock
reset_n  input  1  synchronous reset, active low
data  input  4*NUMBER_OF_DIGITS  hex nybbles; digit i = data[4*i+3:4*i]
dp  input  NUMBER_OF_DIGITS  decimal point per digit (ignored when NUMBER_OF_SEGMENTS=7)
load  input  1  1-clock strobe: capture data/dp into shadow register
brightness  input  4  on-ticks per slot after blanking; 0 = dark
pending  output  1  shadow holds data not yet displayed
frame_sync  output  1  1-clock pulse at start of digit-0 slot
anode  output  NUMBER_OF_DIGITS  digit enables
cathode  output  NUMBER_OF_SEGMENTS  segment drives; bit0=a .. bit6=g, bit7=dp

Behaviour:
- Reset (reset_n=0 at a clock edge, including mid-frame): prescaler, tick, digit counters = 0; shadow, active, brightness_latched = 0; pending = 0; frame_sync = 0; anode and cathode all inactive (polarity per parameters). Outputs are registered.
- Prescaler counts 0..2^CLOCK_DIVIDE_LOG2-1 and produces a 1-clock tick on wrap. tick_in_slot counts 0..15 per tick. digit advances 0..NUMBER_OF_DIGITS-1 on tick_in_slot wrap and wraps to 0 (e.g. 3 digits: 0,1,2,0).
- Frame boundary = the cycle where prescaler, tick_in_slot and digit are all 0 and reset_n=1 (this includes the first cycle after reset release). On that cycle: frame_sync=1; if pending, active <= shadow and pending <= 0; brightness_latched <= brightness.
- load: shadow <= {dp, data}; pending <= 1. Load on a boundary cycle with pending=1: the old shadow transfers and the new data is captured, so pending stays 1. Load on a boundary cycle with pending=0: no transfer that frame; pending becomes 1.
- Each slot: ticks [0, BLANK_TICKS) are fully blank. Ticks [BLANK_TICKS, min(16, BLANK_TICKS+brightness_latched)) have the current digit's anode asserted and the decoded glyph on the cathodes. Remaining ticks are blank. Only one anode is ever asserted.
- Decode uses standard hex glyphs, active-high a..g: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg. dp is OR'd as bit7. Polarity inversion is applied last.
- Registered output latency: anode and cathode reflect the counter state 1 clock later. frame_sync is aligned with that change.

Optional Feature:
SEGMENTED_DISPLAY_LEADING_ZERO_BLANKING_EN.
- Defined: for the active register, scan from digit NUMBER_OF_DIGITS-1 down. Zero nybbles are blanked (a..g inactive) until the first nonzero digit. Digit 0 is never blanked. dp of a blanked digit is still shown. Anode timing is unchanged.
- Undefined: all digits always show their glyph.

Test Plan:
- Defaults; hold reset_n=0 for 5 clocks, then release -> anode=4'b0000, cathode=8'hFF during reset; frame_sync high 1 clock after release and every 1024 clocks after that.
- load data=16'h1234, dp=4'b0001, brightness=15 before first boundary -> digit 0 slot: cathode=~(bcfg|dp)=8'h19 from clock 32 to 255 of the slot, anode=4'b0001; digit 3 shows "1" (8'hF9).
- brightness=0 -> anode stays 4'b0000 all frame; brightness=3 -> each anode is high for exactly 48 clocks per 256-clock slot, starting 32 clocks into the slot.
- Mid-frame load of 16'hABCD -> pending=1, display unchanged until next frame_sync; then pending=0 and digit 0 cathode=~(bcdeg)=8'hA1.
- NUMBER_OF_DIGITS=3 -> anode sequence 001,010,100,001; frame_sync period 768 clocks.
- With SEGMENTED_DISPLAY_LEADING_ZERO_BLANKING_EN defined, data=16'h0050 -> digits 3 and 2 show cathode=8'hFF, digit 1 shows "5", digit 0 shows "0" (8'hC0).

Source files
------------

// File: rtl/segmented_display_mux.sv
// segmented_display_mux: multiplexed 7/8-segment LED display driver.
// One clock domain. A prescaler generates scan ticks, 16 ticks form one digit
// slot, and NUMBER_OF_DIGITS slots form one frame. Each slot starts with
// BLANK_TICKS of dead time to suppress ghosting. After that the digit is lit
// for brightness_latched ticks. New data is loaded into a shadow register and
// moves to the active register only at a frame boundary.
// Optional build macro: SEGMENTED_DISPLAY_LEADING_ZERO_BLANKING_EN blanks
// leading zero digits (digit 0 is always shown).
`timescale 1ns/1ps

module segmented_display_mux #(
  parameter int NUMBER_OF_DIGITS   = 4,   // 1..16
  parameter int NUMBER_OF_SEGMENTS = 8,   // 7 (a..g) or 8 (a..g + dp)
  parameter int CLOCK_DIVIDE_LOG2  = 4,   // scan tick every 2^N clocks
  parameter int BLANK_TICKS        = 2,   // 0..15 dead ticks per slot
  parameter bit ANODE_ACTIVE_HIGH  = 1'b1,
  parameter bit CATHODE_ACTIVE_LOW = 1'b1
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [4*NUMBER_OF_DIGITS-1:0]   data,
  input  logic [NUMBER_OF_DIGITS-1:0]     dp,
  input  logic                            load,
  input  logic [3:0]                      brightness,
  output logic                            pending,
  output logic                            frame_sync,
  output logic [NUMBER_OF_DIGITS-1:0]     anode,
  output logic [NUMBER_OF_SEGMENTS-1:0]   cathode
);

  localparam int DW = (NUMBER_OF_DIGITS > 1) ? $clog2(NUMBER_OF_DIGITS) : 1;
  localparam int PW = (CLOCK_DIVIDE_LOG2 > 0) ? CLOCK_DIVIDE_LOG2 : 1;
  localparam int SW = 5 * NUMBER_OF_DIGITS;  // {dp, data}

  localparam logic [PW-1:0] PRESC_MAX  = PW'((1 << CLOCK_DIVIDE_LOG2) - 1);
  localparam logic [DW-1:0] DIGIT_MAX  = DW'(NUMBER_OF_DIGITS - 1);
  localparam logic [4:0]    BLANK_5    = 5'(BLANK_TICKS);

  // Inactive drive levels; XOR with these applies the pin polarity.
  localparam logic [NUMBER_OF_DIGITS-1:0]   ANODE_OFF   = {NUMBER_OF_DIGITS{!ANODE_ACTIVE_HIGH}};
  localparam logic [NUMBER_OF_SEGMENTS-1:0] CATHODE_OFF = {NUMBER_OF_SEGMENTS{CATHODE_ACTIVE_LOW}};

  // Scan counters
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [3:0]    tick_q, tick_d;
  logic [DW-1:0] digit_q, digit_d;
  logic          scan_tick;
  logic          boundary;

  // Double buffer and brightness
  logic [SW-1:0] shadow_q, shadow_d;
  logic [SW-1:0] active_q, active_d;
  logic          pending_q, pending_d;
  logic [3:0]    bright_q, bright_d;

  // Output registers
  logic                          frame_sync_q;
  logic [NUMBER_OF_DIGITS-1:0]   anode_q, anode_d;
  logic [NUMBER_OF_SEGMENTS-1:0] cathode_q, cathode_d;

  // Current-digit decode
  logic [3:0]                    cur_nybble;
  logic                          cur_dp;
  logic                          cur_blank;
  logic [NUMBER_OF_DIGITS-1:0]   lz_blank;
  logic                          lit_on;
  logic [7:0]                    seg_lit;
  logic [NUMBER_OF_DIGITS-1:0]   anode_lit;
  logic [NUMBER_OF_SEGMENTS-1:0] cathode_lit;

  // Standard hex glyphs, active-high, bit0=a .. bit6=g.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0:    hex_glyph = 7'h3F;
      4'h1:    hex_glyph = 7'h06;
      4'h2:    hex_glyph = 7'h5B;
      4'h3:    hex_glyph = 7'h4F;
      4'h4:    hex_glyph = 7'h66;
      4'h5:    hex_glyph = 7'h6D;
      4'h6:    hex_glyph = 7'h7D;
      4'h7:    hex_glyph = 7'h07;
      4'h8:    hex_glyph = 7'h7F;
      4'h9:    hex_glyph = 7'h6F;
      4'hA:    hex_glyph = 7'h77;
      4'hB:    hex_glyph = 7'h7C;
      4'hC:    hex_glyph = 7'h39;
      4'hD:    hex_glyph = 7'h5E;
      4'hE:    hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  // Prescaler -> tick-in-slot -> digit counter chain and frame boundary detect.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can leave it unassigned (no inferred latch).
    scan_tick   = (prescaler_q == PRESC_MAX);
    prescaler_d = scan_tick ? '0 : prescaler_q + 1'b1;
    tick_d      = scan_tick ? tick_q + 1'b1 : tick_q;   // 4-bit wrap 15 -> 0
    digit_d     = digit_q;
    if (scan_tick && (tick_q == 4'hF)) begin
      digit_d = (digit_q == DIGIT_MAX) ? '0 : digit_q + 1'b1;
    end
    boundary = (prescaler_q == '0) && (tick_q == 4'h0) && (digit_q == '0);
  end

  // Shadow capture, frame-boundary transfer and brightness latch.
  always_comb begin
    shadow_d  = load ? {dp, data} : shadow_q;
    active_d  = (boundary && pending_q) ? shadow_q : active_q;
    bright_d  = boundary ? brightness : bright_q;
    pending_d = pending_q;
    if (load) begin
      pending_d = 1'b1;       // a load always leaves fresh data waiting
    end else if (boundary) begin
      pending_d = 1'b0;
    end
  end

`ifdef SEGMENTED_DISPLAY_LEADING_ZERO_BLANKING_EN
  logic lz_seen;

  // Blank zero digits from the top down until the first nonzero digit.
  always_comb begin
    lz_seen  = 1'b0;
    lz_blank = '0;
    for (int i = NUMBER_OF_DIGITS - 1; i >= 1; i--) begin
      if (!lz_seen && (active_d[4*i +: 4] == 4'h0)) lz_blank[i] = 1'b1;
      if (active_d[4*i +: 4] != 4'h0)               lz_seen     = 1'b1;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Pick the nybble, dp and blanking flag for the digit being scanned.
  always_comb begin
    cur_nybble = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
      if (digit_q == DW'(i)) begin
        cur_nybble = active_d[4*i +: 4];
        cur_dp     = active_d[4*NUMBER_OF_DIGITS + i];
        cur_blank  = lz_blank[i];
      end
    end
  end

  // Slot timing window, glyph decode and polarity; uses the values taking
  // effect this cycle so a boundary frame already shows the new data.
  always_comb begin
    lit_on      = ({1'b0, tick_q} >= BLANK_5) &&
                  ({1'b0, tick_q} <  (BLANK_5 + {1'b0, bright_d}));
    seg_lit     = {cur_dp, cur_blank ? 7'h00 : hex_glyph(cur_nybble)};
    anode_lit   = lit_on ? (NUMBER_OF_DIGITS'(1) << digit_q) : '0;
    cathode_lit = lit_on ? seg_lit[NUMBER_OF_SEGMENTS-1:0] : '0;
    anode_d     = anode_lit ^ ANODE_OFF;
    cathode_d   = cathode_lit ^ CATHODE_OFF;
  end

  // All state, with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      prescaler_q  <= '0;
      tick_q       <= '0;
      digit_q      <= '0;
      // NOTE: shadow and active buffers are reset too, so the first frame is a defined blank-data display.
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      bright_q     <= '0;
      frame_sync_q <= 1'b0;
      anode_q      <= ANODE_OFF;
      cathode_q    <= CATHODE_OFF;
    end else begin
      prescaler_q  <= prescaler_d;
      tick_q       <= tick_d;
      digit_q      <= digit_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      bright_q     <= bright_d;
      frame_sync_q <= boundary;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
    end
  end

  assign pending    = pending_q;
  assign frame_sync = frame_sync_q;
  assign anode      = anode_q;
  assign cathode    = cathode_q;

endmodule

// File: tb/tb_segmented_display_mux.sv
// Directed testbench for segmented_display_mux (default parameters plus a
// 3-digit instance). Frames are 1024 clocks; each output is compared every
// clock against a timing model built from hand-entered glyph constants.
`timescale 1ns/1ps

module tb_segmented_display_mux;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  brightness;
  logic        pending;
  logic        frame_sync;
  logic [3:0]  anode;
  logic [7:0]  cathode;

  logic [11:0] data3;
  logic [2:0]  dp3;
  logic        pending3;
  logic        frame_sync3;
  logic [2:0]  anode3;
  logic [7:0]  cathode3;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_glyph [4];
  int         on_cnt    [4];

  always #5 clock = ~clock;

  segmented_display_mux #(
    .NUMBER_OF_DIGITS(4), .NUMBER_OF_SEGMENTS(8), .CLOCK_DIVIDE_LOG2(4),
    .BLANK_TICKS(2), .ANODE_ACTIVE_HIGH(1'b1), .CATHODE_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .data(data), .dp(dp), .load(load),
    .brightness(brightness), .pending(pending), .frame_sync(frame_sync),
    .anode(anode), .cathode(cathode)
  );

  segmented_display_mux #(
    .NUMBER_OF_DIGITS(3), .NUMBER_OF_SEGMENTS(8), .CLOCK_DIVIDE_LOG2(4),
    .BLANK_TICKS(2), .ANODE_ACTIVE_HIGH(1'b1), .CATHODE_ACTIVE_LOW(1'b1)
  ) u_dut3 (
    .clock(clock), .reset_n(reset_n), .data(data3), .dp(dp3), .load(load),
    .brightness(brightness), .pending(pending3), .frame_sync(frame_sync3),
    .anode(anode3), .cathode(cathode3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample on the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Run one full 1024-clock frame of the 4-digit instance, comparing every clock.
  task automatic run_frame(input string name, input logic [3:0] exp_bright,
                           input logic [3:0] next_bright, input int load_at,
                           input logic [15:0] ld_data, input logic [3:0] ld_dp);
    int an_err = 0;
    int ca_err = 0;
    int fs_err = 0;
    for (int i = 0; i < 4; i++) on_cnt[i] = 0;
    for (int p = 0; p < 1024; p++) begin
      int         slot;
      int         tick;
      bit         lit;
      logic [3:0] ea;
      logic [7:0] ec;
      step();
      load = 1'b0;
      slot = p / 256;
      tick = (p % 256) / 16;
      lit  = (tick >= 2) && (tick < 2 + int'(exp_bright));
      ea   = lit ? 4'(1 << slot) : 4'b0000;
      ec   = lit ? exp_glyph[slot] : 8'hFF;
      if (anode !== ea)                 an_err++;
      if (cathode !== ec)               ca_err++;
      if (frame_sync !== (p == 0))      fs_err++;
      if (anode[slot] === 1'b1)         on_cnt[slot]++;
      if (p == 0) brightness = next_bright;
      if (p == load_at) begin
        data = ld_data;
        dp   = ld_dp;
        load = 1'b1;
      end
    end
    check({name, "_anode_mismatch_clocks"},   an_err, 0);
    check({name, "_cathode_mismatch_clocks"}, ca_err, 0);
    check({name, "_frame_sync_mismatches"},   fs_err, 0);
  endtask

  // Watchdog: the directed sequence is bounded, this only guards against a stall.
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [2:0] seq[$];
    logic [2:0] last_an;
    int         found;
    int         period;
    int         idx;

    reset_n    = 1'b0;
    load       = 1'b0;
    data       = 16'h0000;
    dp         = 4'b0000;
    brightness = 4'h0;
    data3      = 12'h123;
    dp3        = 3'b000;

    // Reset held for 5 clocks: everything inactive.
    repeat (5) step();
    check("reset_anode",       anode,      4'b0000);
    check("reset_cathode",     cathode,    8'hFF);
    check("reset_frame_sync",  frame_sync, 1'b0);
    check("reset_pending",     pending,    1'b0);
    check("reset_anode3",      anode3,     3'b000);
    check("reset_cathode3",    cathode3,   8'hFF);

    // Frame 0: brightness latched 0 -> dark. Load 1234/dp0 mid-frame.
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_glyph[i] = 8'hFF;
    run_frame("f0", 4'd0, 4'd15, 0, 16'h1234, 4'b0001);
    check("f0_end_pending", pending, 1'b1);

    // Frame 1: 1234 with dp on digit 0, full brightness.
    exp_glyph = '{8'h19, 8'hB0, 8'hA4, 8'hF9};
    run_frame("f1", 4'd15, 4'd0, -1, 16'h0000, 4'b0000);
    check("f1_end_pending", pending, 1'b0);
    check("f1_digit0_on_clocks", on_cnt[0], 224);

    // Frame 2: brightness 0 -> dark all frame.
    run_frame("f2", 4'd0, 4'd3, -1, 16'h0000, 4'b0000);

    // Frame 3: brightness 3 -> 48 clocks per digit; load ABCD mid-frame.
    run_frame("f3", 4'd3, 4'd15, 500, 16'hABCD, 4'b0000);
    for (int i = 0; i < 4; i++) check($sformatf("f3_digit%0d_on_clocks", i), on_cnt[i], 48);
    check("f3_end_pending", pending, 1'b1);

    // Frame 4: ABCD shown; load 0050 on the clock that lands on the next boundary.
    exp_glyph = '{8'hA1, 8'hC6, 8'h83, 8'h88};
    run_frame("f4", 4'd15, 4'd15, 1023, 16'h0050, 4'b0000);
    check("f4_end_pending", pending, 1'b0);

    // Frame 5: boundary load with nothing pending -> no transfer, ABCD remains.
    run_frame("f5", 4'd15, 4'd15, -1, 16'h0000, 4'b0000);
    check("f5_end_pending", pending, 1'b1);

    // Frame 6: 0050 shown.
`ifdef SEGMENTED_DISPLAY_LEADING_ZERO_BLANKING_EN
    exp_glyph = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
`else
    exp_glyph = '{8'hC0, 8'h92, 8'hC0, 8'hC0};
`endif
    run_frame("f6", 4'd15, 4'd15, -1, 16'h0000, 4'b0000);
    check("f6_end_pending", pending, 1'b0);

    // Mid-frame reset while digit 0 is lit and a load is pending.
    for (int p = 0; p < 40; p++) begin
      step();
      load = 1'b0;
      if (p == 5) begin
        data = 16'h9999;
        load = 1'b1;
      end
    end
    check("pre_reset_anode",   anode,   4'b0001);
    check("pre_reset_cathode", cathode, 8'hC0);
    check("pre_reset_pending", pending, 1'b1);
    reset_n = 1'b0;
    step();
    check("midreset_anode",      anode,      4'b0000);
    check("midreset_cathode",    cathode,    8'hFF);
    check("midreset_pending",    pending,    1'b0);
    check("midreset_frame_sync", frame_sync, 1'b0);
    reset_n = 1'b1;
    step();
    check("release_frame_sync",  frame_sync, 1'b1);

    // 3-digit instance: frame period 768 and anode order 001,010,100,001.
    found = 0;
    for (int n = 0; n < 1000 && found == 0; n++) begin
      step();
      if (frame_sync3 === 1'b1) found = 1;
    end
    check("d3_first_frame_sync_seen", found, 1);
    period  = 0;
    idx     = 0;
    last_an = 3'b000;
    for (int n = 0; n < 1000 && (period == 0 || seq.size() < 4); n++) begin
      if (anode3 !== 3'b000 && anode3 !== last_an && seq.size() < 4) begin
        seq.push_back(anode3);
        last_an = anode3;
      end
      step();
      idx++;
      if (frame_sync3 === 1'b1 && period == 0) period = idx;
    end
    check("d3_frame_period", period, 768);
    check("d3_anode_seq_len", seq.size(), 4);
    while (seq.size() < 4) seq.push_back(3'b000);
    check("d3_anode_seq0", seq[0], 3'b001);
    check("d3_anode_seq1", seq[1], 3'b010);
    check("d3_anode_seq2", seq[2], 3'b100);
    check("d3_anode_seq3", seq[3], 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
